div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 19 +
 rtl/div_ctrl_core.sv | 53 +++++
 rtl/div_ctrl.sv | 120 ++++++++++++
 tb/tb_div_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
// Shared definitions for the programmable clock divider:
//   state_t      - control FSM states (IDLE / RUN / STOP)
//   CNT_W_DEF    - default width of the half-period terminal count
//   DEF_HALF_DEF - default terminal count loaded at reset (9 -> divide-by-20)
//   PERIOD_CNT_W - width of the optional output-period counter
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int CNT_W_DEF    = 6;
  localparam int DEF_HALF_DEF = 9;
  localparam int PERIOD_CNT_W = 16;

endpackage

// File: rtl/div_ctrl_core.sv
// div_ctrl_core
// Half-period counter and divided-clock toggle.
// Ports:
//   clk      in   clock (rising edge)
//   rst_n    in   asynchronous active-low reset
//   run      in   1 = count; 0 = hold everything at the idle values
//   terminal in   terminal count T; each half-period lasts T+1 cycles
//   at_term  out  counter currently equals the terminal count
//   o_clk    out  divided clock (registered)
//   o_tick   out  one-cycle pulse during the first cycle o_clk is high
module div_ctrl_core
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_term,
  output logic             o_clk,
  output logic             o_tick
);

  logic [CNT_W-1:0] cnt_reg;
  logic             o_clk_reg;
  logic             o_tick_reg;

  assign at_term = (cnt_reg == terminal);
  assign o_clk   = o_clk_reg;
  assign o_tick  = o_tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      o_clk_reg  <= 1'b0;
      o_tick_reg <= 1'b0;
    end else if (!run) begin
      cnt_reg    <= '0;
      o_clk_reg  <= 1'b0;
      o_tick_reg <= 1'b0;
    end else if (at_term) begin
      // The terminal cycle restarts the count, so cnt never passes terminal.
      cnt_reg    <= '0;
      o_clk_reg  <= ~o_clk_reg;
      o_tick_reg <= ~o_clk_reg;  // pulse only on the 0->1 toggle
    end else begin
      cnt_reg    <= cnt_reg + CNT_W'(1);
      o_tick_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl
// Programmable clock divider with a run/stop FSM and a valid/ready ratio port.
// A new ratio is parked in a one-deep pending register and only takes effect
// in IDLE or at an O_CLK 1->0 toggle, so output half-periods are never cut.
// Ports:
//   I_CLK      in   clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   en         in   level run request
//   cfg_valid  in   new-ratio request
//   cfg_half   in   requested terminal count T (half-period = T+1 cycles)
//   cfg_ready  out  ratio-request accept (high when nothing is pending)
//   O_CLK      out  divided clock, registered
//   O_TICK     out  one-cycle pulse in the cycle O_CLK goes 0->1
//   busy       out  high in RUN and STOP
//   cur_half   out  terminal count currently in force
//   period_cnt out  (only with DIV_CTRL_PERIOD_CNT_EN) count of O_TICK pulses
// Build option: define DIV_CTRL_PERIOD_CNT_EN to add period_cnt.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic                    I_CLK,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cfg_valid,
  input  logic [CNT_W-1:0]        cfg_half,
  output logic                    cfg_ready,
  output logic                    O_CLK,
  output logic                    O_TICK,
  output logic                    busy,
  output logic [CNT_W-1:0]        cur_half
`ifdef DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEF_HALF_V = DEF_HALF[CNT_W-1:0];

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cur_half_reg;
  logic [CNT_W-1:0] pend_half_reg;
  logic             pend_valid_reg;
  logic             at_term;
  logic             run;
  logic             boundary;
  logic             load;
  logic             accept;

  // Leaving RUN/STOP with O_CLK low (or at the falling toggle) goes straight
  // to IDLE: the stop phase has nothing left to finish.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (en) state_next = RUN;
      RUN:  if (!en) state_next = (!O_CLK || at_term) ? IDLE : STOP;
      STOP: begin
        if (en)                     state_next = RUN;
        else if (!O_CLK || at_term) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);
  // Core counts only while staying busy; the entry cycle and the exit cycle
  // both hold it cleared, giving the T+1 latency to the first rise.
  assign run = busy && (state_next != IDLE);
  // Period boundary = the O_CLK 1->0 toggle.
  assign boundary = busy && O_CLK && at_term;
  // Load uses the registered pending flag, so a same-cycle transfer waits.
  assign load   = pend_valid_reg && (!busy || boundary);
  assign accept = cfg_valid && !pend_valid_reg;

  assign cfg_ready = ~pend_valid_reg;
  assign cur_half  = cur_half_reg;

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cur_half_reg   <= DEF_HALF_V;
      pend_half_reg  <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        cur_half_reg   <= pend_half_reg;
        pend_valid_reg <= 1'b0;
      end else if (accept) begin
        pend_half_reg  <= cfg_half;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  div_ctrl_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (I_CLK),
    .rst_n   (rst_n),
    .run     (run),
    .terminal(cur_half_reg),
    .at_term (at_term),
    .o_clk   (O_CLK),
    .o_tick  (O_TICK)
  );

`ifdef DIV_CTRL_PERIOD_CNT_EN
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) period_cnt <= '0;
    else if (O_TICK) period_cnt <= period_cnt + PERIOD_CNT_W'(1);
  end
`else
  // No period counter in this build.
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl
// Self-checking bench for div_ctrl: reset values, a table of ratios measured
// from the waveform, hand-written stop/restart/ratio-change/reset sequences,
// and a randomized ratio stream checked against a timestamp-based model.
module tb_div_ctrl;

  localparam int CNT_W = 6;
  localparam int LIMIT = 400;

  logic             I_CLK = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_ready;
  logic             O_CLK;
  logic             O_TICK;
  logic             busy;
  logic [CNT_W-1:0] cur_half;
`ifdef DIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(9)) dut (
    .I_CLK    (I_CLK),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .O_CLK    (O_CLK),
    .O_TICK   (O_TICK),
    .busy     (busy),
    .cur_half (cur_half)
`ifdef DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) ecount <= ecount + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Counts consecutive samples (from the current one) with O_CLK == lvl.
  task automatic run_len(input logic lvl, output int n, output int ticks);
    n = 0;
    ticks = 0;
    while (O_CLK == lvl && n < LIMIT) begin
      n++;
      ticks += int'(O_TICK);
      @(negedge I_CLK);
    end
  endtask

  task automatic wait_level(input logic lvl);
    int k;
    k = 0;
    while (O_CLK != lvl && k < LIMIT) begin
      @(negedge I_CLK);
      k++;
    end
    chk("wait_level", int'(O_CLK), int'(lvl));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < LIMIT) begin
      @(negedge I_CLK);
      k++;
    end
    chk("wait_idle busy", int'(busy), 0);
  endtask

  task automatic set_ratio_idle(input int t);
    cfg_valid = 1'b1;
    cfg_half  = t[CNT_W-1:0];
    @(negedge I_CLK);
    cfg_valid = 1'b0;
    chk("idle pend cfg_ready", int'(cfg_ready), 0);
    @(negedge I_CLK);
    chk("idle load cur_half", int'(cur_half), t);
    chk("idle ready after load", int'(cfg_ready), 1);
  endtask

  typedef struct {
    int t;
    int exp_first;
    int exp_high;
    int exp_low;
    int exp_stop_high;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k, h, th, l, tl, h2, t2, f0, f1, f2, rdy_seen, hsel;
    logic v;
    int m_T, m_pT, m_next;
    logic m_lvl, m_pv, m_tick, rdy;

    vecs[0] = '{0, 1, 1, 1, 1};
    vecs[1] = '{1, 2, 2, 2, 2};
    vecs[2] = '{2, 3, 3, 3, 3};
    vecs[3] = '{9, 10, 10, 10, 10};
    vecs[4] = '{63, 64, 64, 64, 64};

    // ---------------- reset state ----------------
    repeat (2) @(negedge I_CLK);
    chk("reset O_CLK", int'(O_CLK), 0);
    chk("reset O_TICK", int'(O_TICK), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset cfg_ready", int'(cfg_ready), 1);
    chk("reset cur_half", int'(cur_half), 9);
    rst_n = 1'b1;
    @(negedge I_CLK);
    chk("post-release busy", int'(busy), 0);
    $display("reset: O_CLK=%0d busy=%0d cur_half=%0d", O_CLK, busy, cur_half);

    // ---------------- table of ratios ----------------
    for (int i = 0; i < 5; i++) begin
      set_ratio_idle(vecs[i].t);
      en = 1'b1;
      k = 0;
      do begin
        @(negedge I_CLK);
        k++;
      end while (O_CLK == 1'b0 && k < LIMIT);
      chk("vec first_rise", k - 1, vecs[i].exp_first);
      chk("vec tick at rise", int'(O_TICK), 1);
      chk("vec busy in RUN", int'(busy), 1);
      run_len(1'b1, h, th);
      run_len(1'b0, l, tl);
      chk("vec high len", h, vecs[i].exp_high);
      chk("vec ticks in high", th, 1);
      chk("vec low len", l, vecs[i].exp_low);
      chk("vec ticks in low", tl, 0);
      en = 1'b0;
      run_len(1'b1, h2, t2);
      chk("vec stop high len", h2, vecs[i].exp_stop_high);
      chk("vec stop busy", int'(busy), 0);
      $display("vec %0d: T=%0d first_rise=%0d high=%0d low=%0d stop_high=%0d",
               i, vecs[i].t, k - 1, h, l, h2);
    end

    // ---------------- en dropped during low phase ----------------
    set_ratio_idle(9);
    en = 1'b1;
    wait_level(1'b1);
    wait_level(1'b0);
    en = 1'b0;
    @(negedge I_CLK);
    chk("low stop busy", int'(busy), 0);
    chk("low stop O_CLK", int'(O_CLK), 0);
    repeat (3) @(negedge I_CLK);
    chk("low stop O_CLK held", int'(O_CLK), 0);
    $display("seq low-phase stop: busy=%0d O_CLK=%0d", busy, O_CLK);

    // ---------------- en glitch inside high phase ----------------
    en = 1'b1;
    wait_level(1'b1);
    en = 1'b0;
    @(negedge I_CLK);
    chk("glitch busy in STOP", int'(busy), 1);
    chk("glitch O_CLK high", int'(O_CLK), 1);
    en = 1'b1;
    run_len(1'b1, h, th);
    run_len(1'b0, l, tl);
    chk("glitch rest of high", h, 9);
    chk("glitch low len", l, 10);
    $display("seq en glitch: rest_high=%0d low=%0d", h, l);
    en = 1'b0;
    wait_idle();

    // ---------------- ratio change while running ----------------
    en = 1'b1;
    wait_level(1'b1);
    wait_level(1'b0);
    f0 = ecount;
    wait_level(1'b1);
    repeat (3) @(negedge I_CLK);
    cfg_valid = 1'b1;
    cfg_half  = 6'd2;
    @(negedge I_CLK);
    cfg_half = 6'd4;  // second request held while the first is pending
    chk("chg ready low after accept", int'(cfg_ready), 0);
    chk("chg cur_half unchanged", int'(cur_half), 9);
    rdy_seen = 0;
    k = 0;
    while (O_CLK == 1'b1 && k < LIMIT) begin
      @(negedge I_CLK);
      if (O_CLK) rdy_seen += int'(cfg_ready);
      k++;
    end
    chk("chg ready stayed low", rdy_seen, 0);
    f1 = ecount;
    chk("chg period before load", f1 - f0, 20);
    chk("chg cur_half loaded", int'(cur_half), 2);
    chk("chg ready after load", int'(cfg_ready), 1);
    @(negedge I_CLK);
    cfg_valid = 1'b0;
    chk("chg held value accepted", int'(cfg_ready), 0);
    chk("chg no bypass", int'(cur_half), 2);
    wait_level(1'b1);
    wait_level(1'b0);
    f2 = ecount;
    chk("chg period T=2", f2 - f1, 6);
    chk("chg cur_half second", int'(cur_half), 4);
    wait_level(1'b1);
    wait_level(1'b0);
    chk("chg period T=4", ecount - f2, 10);
    $display("seq ratio change: p0=%0d p1=%0d p2=%0d", f1 - f0, f2 - f1, ecount - f2);
    en = 1'b0;
    wait_idle();

    // ---------------- reset mid-period with a pending ratio ----------------
    set_ratio_idle(3);
    en = 1'b1;
    wait_level(1'b1);
    @(negedge I_CLK);
    cfg_valid = 1'b1;
    cfg_half  = 6'd5;
    @(negedge I_CLK);
    cfg_valid = 1'b0;
    chk("rst pending before", int'(cfg_ready), 0);
    chk("rst O_CLK before", int'(O_CLK), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async O_CLK", int'(O_CLK), 0);
    chk("rst async O_TICK", int'(O_TICK), 0);
    chk("rst async busy", int'(busy), 0);
    chk("rst async cfg_ready", int'(cfg_ready), 1);
    chk("rst async cur_half", int'(cur_half), 9);
`ifdef DIV_CTRL_PERIOD_CNT_EN
    chk("rst async period_cnt", int'(period_cnt), 0);
`endif
    en = 1'b0;
    #4 rst_n = 1'b1;
    repeat (3) @(negedge I_CLK);
    chk("rst pending lost", int'(cur_half), 9);
    chk("rst ready after", int'(cfg_ready), 1);
    chk("rst idle after", int'(busy), 0);
    $display("seq reset: cur_half=%0d cfg_ready=%0d", cur_half, cfg_ready);

    // ---------------- randomized ratio stream vs model ----------------
    // Model: toggles happen at timestamps start + T + 1; a pending ratio
    // replaces T at a falling toggle; one-deep pending buffer.
    m_T = 9; m_pT = 0; m_next = 0;
    m_lvl = 1'b0; m_pv = 1'b0; m_tick = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      v = 1'b0;
      hsel = 0;
      if (i > 0) begin
        v = ($urandom_range(0, 3) == 0);
        hsel = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 12));
      end
      cfg_valid = v;
      cfg_half  = hsel[CNT_W-1:0];
      @(negedge I_CLK);
      rdy = !m_pv;
      m_tick = 1'b0;
      if (i == 0) begin
        m_next = m_T + 1;
      end else if (i == m_next) begin
        m_lvl  = !m_lvl;
        m_tick = m_lvl;
        if (!m_lvl && m_pv) begin
          m_T  = m_pT;
          m_pv = 1'b0;
        end
        m_next = i + m_T + 1;
      end
      if (v && rdy) begin
        m_pv = 1'b1;
        m_pT = hsel;
        $display("rnd xfer @%0d: T=%0d", i, hsel);
      end
      chk($sformatf("rnd O_CLK @%0d", i), int'(O_CLK), int'(m_lvl));
      chk($sformatf("rnd O_TICK @%0d", i), int'(O_TICK), int'(m_tick));
      chk($sformatf("rnd cur_half @%0d", i), int'(cur_half), m_T);
      chk($sformatf("rnd cfg_ready @%0d", i), int'(cfg_ready), int'(!m_pv));
      chk($sformatf("rnd busy @%0d", i), int'(busy), 1);
    end
    cfg_valid = 1'b0;
    en = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
